ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of the adder, ALU and read-data-2 paths.
REQ-003 Parameter REG_W, default 5, SHALL set the width of the destination-register number.
REQ-004 clk  in  1  SHALL be the rising-edge clock for all state.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 stall  in  1  SHALL hold all outputs when high.
REQ-007 flush  in  1  SHALL be the bubble insert; it is present only when EX_MEM_FLUSH_EN is defined.
REQ-008 ctlwb_out  in  2  SHALL carry the write-back control bits from EX.
REQ-009 ctlm_out  in  3  SHALL carry the memory control bits from EX.
REQ-010 adder_out  in  DATA_W  SHALL carry the branch-target adder result.
REQ-011 aluzero  in  1  SHALL carry the ALU zero flag.
REQ-012 aluout  in  DATA_W  SHALL carry the ALU result.
REQ-013 readdat2  in  DATA_W  SHALL carry register-file read data 2 (store data).
REQ-014 muxout  in  REG_W  SHALL carry the destination register number.
REQ-015 Outputs wb_ctlout (2), m_ctlout (3), add_result (DATA_W), zero (1), alu_result (DATA_W), rdata2out (DATA_W) and five_bit_muxout (REG_W) SHALL be the registered copies of the respective inputs in REQ-008..014.

Function
REQ-016 On each rising clk edge with rst=0, stall=0 and flush inactive, every output SHALL take its input's value; latency SHALL be exactly 1 cycle.
REQ-017 Outputs SHALL change only on a rising clk edge; input changes between edges SHALL NOT appear at the outputs (no combinational path).
REQ-018 When stall=1 (and rst=0, flush inactive), all outputs SHALL keep their previous values.
REQ-019 When flush is active (and rst=0), wb_ctlout and m_ctlout SHALL load 0 while the data outputs load their inputs normally.
REQ-020 Edge priority SHALL be rst > flush > stall > load; flush overrides stall.
REQ-021 Widths SHALL be passed through bit-exact, with no extension, truncation or arithmetic.

Reset
REQ-022 With rst=1 at a rising edge, every output SHALL become 0.
REQ-023 Reset asserted while the pipeline is running SHALL discard the pending inputs at that edge.
REQ-024 Before the first reset edge the outputs are undefined; the bench SHALL reset before checking.

Configuration
REQ-025 With `EX_MEM_FLUSH_EN` defined, the flush port and REQ-019 SHALL exist.
REQ-026 Without `EX_MEM_FLUSH_EN`, the flush port SHALL be absent and behaviour SHALL be as if flush=0.

Verification
REQ-027 Reset: rst=1 for one edge with all inputs nonzero -> all outputs are 0.
REQ-028 Load: ctlwb=01, ctlm=101, adder=00FF1133, aluzero=0, aluout=00FFFFFF, readdat2=005100C3, muxout=00101 -> the same values appear after the next edge and not before it.
REQ-029 Load: ctlwb=10, ctlm=001, adder=00FF1100, aluout=00FFFF23, readdat2=00F3DD10, muxout=00011 -> the outputs update one edge later, and the previous values are held until that edge.
REQ-030 Stall: stall=1 with new inputs for 3 edges -> outputs unchanged; stall=0 -> the new values appear after 1 edge.
REQ-031 Flush (macro on): flush=1 with ctlwb=11, ctlm=111, aluout=12345678 -> wb_ctlout=00, m_ctlout=000, alu_result=12345678; flush together with stall behaves the same way.
REQ-032 Priority: rst=1 together with stall=1 and flush=1 -> all outputs are 0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: one-cycle registered copy of the EX stage results with stall hold.
// Optional bubble insert (control bits cleared) when EX_MEM_FLUSH_EN is defined.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
`ifdef EX_MEM_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [1:0]        ctlwb_out,
    input  logic [2:0]        ctlm_out,
    input  logic [DATA_W-1:0] adder_out,
    input  logic              aluzero,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] readdat2,
    input  logic [REG_W-1:0]  muxout,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [DATA_W-1:0] add_result,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_W-1:0]  five_bit_muxout
);

    logic              flush_act;
    logic [1:0]        wb_q,   wb_d;
    logic [2:0]        m_q,    m_d;
    logic [DATA_W-1:0] add_q,  add_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] alu_q,  alu_d;
    logic [DATA_W-1:0] rd2_q,  rd2_d;
    logic [REG_W-1:0]  rd_q,   rd_d;

`ifdef EX_MEM_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // A flush overrides a stall: the stage advances, but as a bubble.
    always_comb begin
        // NOTE: hold values are assigned first so every path drives every _d and no latch is inferred.
        wb_d   = wb_q;
        m_d    = m_q;
        add_d  = add_q;
        zero_d = zero_q;
        alu_d  = alu_q;
        rd2_d  = rd2_q;
        rd_d   = rd_q;
        if (flush_act || !stall) begin
            wb_d   = flush_act ? 2'b00  : ctlwb_out;
            m_d    = flush_act ? 3'b000 : ctlm_out;
            add_d  = adder_out;
            zero_d = aluzero;
            alu_d  = aluout;
            rd2_d  = readdat2;
            rd_d   = muxout;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            wb_q   <= '0;
            m_q    <= '0;
            add_q  <= '0;
            zero_q <= 1'b0;
            alu_q  <= '0;
            rd2_q  <= '0;
            rd_q   <= '0;
        end else begin
            wb_q   <= wb_d;
            m_q    <= m_d;
            add_q  <= add_d;
            zero_q <= zero_d;
            alu_q  <= alu_d;
            rd2_q  <= rd2_d;
            rd_q   <= rd_d;
        end
    end

    assign wb_ctlout       = wb_q;
    assign m_ctlout        = m_q;
    assign add_result      = add_q;
    assign zero            = zero_q;
    assign alu_result      = alu_q;
    assign rdata2out       = rd2_q;
    assign five_bit_muxout = rd_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg; flush scenarios run only when EX_MEM_FLUSH_EN is defined.
module tb_ex_mem_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [1:0]        wb;
        logic [2:0]        m;
        logic [DATA_W-1:0] add;
        logic              z;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
        logic [REG_W-1:0]  mux;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, stall, flush;
    logic [1:0]        ctlwb_out;
    logic [2:0]        ctlm_out;
    logic [DATA_W-1:0] adder_out, aluout, readdat2;
    logic              aluzero;
    logic [REG_W-1:0]  muxout;
    logic [1:0]        wb_ctlout;
    logic [2:0]        m_ctlout;
    logic [DATA_W-1:0] add_result, alu_result, rdata2out;
    logic              zero;
    logic [REG_W-1:0]  five_bit_muxout;

    ex_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
`ifdef EX_MEM_FLUSH_EN
        .flush           (flush),
`endif
        .ctlwb_out       (ctlwb_out),
        .ctlm_out        (ctlm_out),
        .adder_out       (adder_out),
        .aluzero         (aluzero),
        .aluout          (aluout),
        .readdat2        (readdat2),
        .muxout          (muxout),
        .wb_ctlout       (wb_ctlout),
        .m_ctlout        (m_ctlout),
        .add_result      (add_result),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bundle_t dut_out();
        dut_out = {wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out, five_bit_muxout};
    endfunction

    function automatic bundle_t rand_b();
        rand_b.wb  = 2'($urandom);
        rand_b.m   = 3'($urandom);
        rand_b.add = $urandom;
        rand_b.z   = 1'($urandom);
        rand_b.alu = $urandom;
        rand_b.rd2 = $urandom;
        rand_b.mux = 5'($urandom);
    endfunction

    bundle_t model;
    bit      model_valid = 1'b0;
    bundle_t exp_q[$];

    // Drive one cycle of stimulus, push its expected result, check hold before the edge
    // and the popped expectation after it.
    task automatic step(input string tag, input bundle_t in, input logic r, input logic s, input logic f);
        bundle_t e;
        @(negedge clk);
`ifndef EX_MEM_FLUSH_EN
        f = 1'b0;
`endif
        rst   = r;
        stall = s;
        flush = f;
        {ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdat2, muxout} = in;
        if (r)      e = '0;
        else if (f) begin e = in; e.wb = '0; e.m = '0; end
        else if (s) e = model;
        else        e = in;
        exp_q.push_back(e);
        #1;
        if (model_valid) check({tag, "/pre_edge"}, dut_out(), model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, dut_out(), e);
        model       = e;
        model_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        {ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdat2, muxout} = '1;

        // Reset with all inputs nonzero
        step("reset", '1, 1'b1, 1'b0, 1'b0);

        step("load1", '{wb:2'b01, m:3'b101, add:32'h00FF1133, z:1'b0,
                        alu:32'h00FFFFFF, rd2:32'h005100C3, mux:5'b00101}, 1'b0, 1'b0, 1'b0);
        step("load2", '{wb:2'b10, m:3'b001, add:32'h00FF1100, z:1'b1,
                        alu:32'h00FFFF23, rd2:32'h00F3DD10, mux:5'b00011}, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("stall", rand_b(), 1'b0, 1'b1, 1'b0);
        step("unstall", rand_b(), 1'b0, 1'b0, 1'b0);

`ifdef EX_MEM_FLUSH_EN
        b = rand_b(); b.wb = 2'b11; b.m = 3'b111; b.alu = 32'h12345678;
        step("flush", b, 1'b0, 1'b0, 1'b1);
        step("reload", rand_b(), 1'b0, 1'b0, 1'b0);
        b = rand_b(); b.wb = 2'b11; b.m = 3'b111; b.alu = 32'h12345678;
        step("flush_stall", b, 1'b0, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 24; i++)
            step("random", rand_b(), 1'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));

        // Reset beats flush and stall, discarding the pending inputs
        step("rst_prio", '1, 1'b1, 1'b1, 1'b1);
        step("post_rst_stall", rand_b(), 1'b0, 1'b1, 1'b0);
        step("post_rst_load", rand_b(), 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
